// File: rtl/frame_word_reader_if.sv
// Signal bundle between the frame word reader, the SDRAM read FIFO and the HPS.
// Word handshake: oWORD is offered with oWORD_VALID=1 and held stable until iWORD_ACK=1 is sampled;
// VALID then drops, and no new word is fetched until iWORD_ACK has been seen low again (four-phase).
interface frame_word_reader_if;
  logic        iSTART;
  logic        iABORT;
  logic [15:0] iRD_DATA;
  logic        oRD;
  logic        oRD_LOAD;
  logic [31:0] oWORD;
  logic        oWORD_VALID;
  logic        iWORD_ACK;
  logic [11:0] oWORD_COUNT;
  logic        oBUSY;
  logic        oFRAME_DONE;
  logic [2:0]  oSTATE;

  modport master (
    input  iSTART, iABORT, iRD_DATA, iWORD_ACK,
    output oRD, oRD_LOAD, oWORD, oWORD_VALID, oWORD_COUNT, oBUSY, oFRAME_DONE, oSTATE
  );

  modport slave (
    output iSTART, iABORT, iRD_DATA, iWORD_ACK,
    input  oRD, oRD_LOAD, oWORD, oWORD_VALID, oWORD_COUNT, oBUSY, oFRAME_DONE, oSTATE
  );
endinterface

// File: rtl/frame_word_reader.sv
// Reads one black/white frame from the SDRAM read FIFO and hands it to the HPS
// as 32-pixel words, LSB = first pixel, over a four-phase valid/ack handshake.
module frame_word_reader #(
  parameter int FRAME_PIXELS = 76800,
  parameter int PIX_BIT      = 13,
  parameter int LOAD_CYCLES  = 4
) (
  input  logic iCLK,
  input  logic iRST_N,
  frame_word_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FETCH   = 3'd2,
    PRESENT = 3'd3,
    ACK_LOW = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [16:0] FRAME_END  = 17'(FRAME_PIXELS);
  localparam logic [5:0]  LOAD_LAST  = 6'(LOAD_CYCLES - 1);
  localparam logic [5:0]  FETCH_LAST = 6'd32;

  state_e      state_q, state_d;
  logic [5:0]  cyc_q, cyc_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic [16:0] pix_q, pix_d;
  logic [11:0] count_q, count_d;
  logic        pix_in;

  assign pix_in = bus.iRD_DATA[PIX_BIT];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      pix_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      pix_q   <= pix_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    shift_d = shift_q;
    word_d  = word_q;
    pix_d   = pix_q;
    count_d = count_q;
    if (bus.iABORT) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.iSTART) begin
            state_d = LOAD;
            cyc_d   = '0;
            pix_d   = '0;
            count_d = '0;
          end
        end
        LOAD: begin
          if (cyc_q == LOAD_LAST) begin
            state_d = FETCH;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 6'd1;
          end
        end
        FETCH: begin
          // FIFO data lags the read strobe by one cycle, so capture runs on cycles 1..32.
          if (cyc_q != 6'd0) shift_d = {pix_in, shift_q[31:1]};
          if (cyc_q == FETCH_LAST) begin
            state_d = PRESENT;
            word_d  = shift_d;
            pix_d   = pix_q + 17'd32;
          end else begin
            cyc_d = cyc_q + 6'd1;
          end
        end
        PRESENT: begin
          if (bus.iWORD_ACK) begin
            state_d = ACK_LOW;
            count_d = count_q + 12'd1;
          end
        end
        ACK_LOW: begin
          if (!bus.iWORD_ACK) begin
            if (pix_q < FRAME_END) begin
              state_d = FETCH;
              cyc_d   = '0;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.oRD         = (state_q == FETCH) && (cyc_q < FETCH_LAST);
  assign bus.oRD_LOAD    = (state_q == LOAD);
  assign bus.oWORD       = word_q;
  assign bus.oWORD_VALID = (state_q == PRESENT);
  assign bus.oWORD_COUNT = count_q;
  assign bus.oBUSY       = (state_q != IDLE);
  assign bus.oFRAME_DONE = (state_q == DONE);
  assign bus.oSTATE      = state_q;

endmodule

// File: doc/frame_word_reader.md
FRAME_WORD_READER -- requirements
Module: frame_word_reader

Interface
REQ-001 The block SHALL have parameter FRAME_PIXELS, default 76800, meaning the pixels per frame (320x240); it SHALL be a multiple of 32.
REQ-002 The block SHALL have parameter PIX_BIT, default 13, meaning the bit index of iRD_DATA that carries the black/white pixel.
REQ-003 The block SHALL have parameter LOAD_CYCLES, default 4, meaning the number of cycles oRD_LOAD is held high.
REQ-004 The block SHALL have port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port iRST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port iSTART, input, 1 bit: frame read request, sampled only in IDLE.
REQ-007 The block SHALL have port iABORT, input, 1 bit: synchronous abandon of the current frame.
REQ-008 The block SHALL have port iRD_DATA, input, 16 bits: SDRAM read-FIFO data, valid the cycle after oRD is high.
REQ-009 The block SHALL have port oRD, output, 1 bit: SDRAM read-FIFO read request.
REQ-010 The block SHALL have port oRD_LOAD, output, 1 bit: SDRAM read-port address reload.
REQ-011 The block SHALL have port oWORD, output, 32 bits: 32 packed pixels.
REQ-012 The block SHALL have port oWORD_VALID, output, 1 bit: oWORD holds a new word.
REQ-013 The block SHALL have port iWORD_ACK, input, 1 bit: HPS acknowledge.
REQ-014 The block SHALL have port oWORD_COUNT, output, 12 bits: words handed over in the current frame.
REQ-015 The block SHALL have port oBUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port oFRAME_DONE, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, FETCH, PRESENT, ACK_LOW and DONE.
REQ-018 In IDLE with iSTART=1, the FSM SHALL go to LOAD, clear the pixel counter and clear oWORD_COUNT.
REQ-019 In LOAD, oRD_LOAD SHALL be 1 for exactly LOAD_CYCLES cycles, then the FSM SHALL go to FETCH; oRD SHALL be 0 throughout LOAD.
REQ-020 In FETCH, oRD SHALL be 1 for exactly 32 consecutive cycles (relative cycles 0..31).
REQ-021 iRD_DATA[PIX_BIT] SHALL be captured on cycles 1..32; the k-th captured pixel (k=0..31) SHALL land in word bit k (LSB-first).
REQ-022 On cycle 33, oWORD SHALL update and oWORD_VALID SHALL rise, with the FSM in PRESENT.
REQ-023 oWORD SHALL be stable while oWORD_VALID=1.
REQ-024 The HPS handshake SHALL be four-phase: in PRESENT, oWORD_VALID SHALL stay 1 until iWORD_ACK=1 is sampled.
REQ-025 When iWORD_ACK=1 is sampled, oWORD_VALID SHALL drop the next cycle, oWORD_COUNT SHALL increment by 1, and the FSM SHALL go to ACK_LOW.
REQ-026 In ACK_LOW, when iWORD_ACK=0 is sampled, the FSM SHALL go to FETCH if the pixel count is below FRAME_PIXELS, otherwise to DONE.
REQ-027 iWORD_ACK SHALL be ignored in every state other than PRESENT and ACK_LOW.
REQ-028 In DONE, oFRAME_DONE SHALL be 1 for one cycle, then the FSM SHALL go to IDLE.
REQ-029 The pixel counter SHALL be 17 bits and SHALL add 32 per word.
REQ-030 The frame SHALL end exactly at FRAME_PIXELS; the counter SHALL never wrap within a frame.
REQ-031 iSTART outside IDLE SHALL be ignored.
REQ-032 iABORT=1 in any state SHALL force IDLE on the next edge with oRD=0, oRD_LOAD=0 and oWORD_VALID=0; oFRAME_DONE SHALL NOT pulse.
REQ-033 If iABORT and iSTART are high in the same cycle, iABORT SHALL win.
REQ-034 oWORD_COUNT SHALL hold its value after DONE or abort until the next accepted iSTART.

Reset
REQ-035 While iRST_N=0, asynchronously: state=IDLE, oRD=0, oRD_LOAD=0, oWORD=0, oWORD_VALID=0, oWORD_COUNT=0, oBUSY=0, oFRAME_DONE=0, pixel counter=0.
REQ-036 Reset asserted mid-FETCH or mid-PRESENT SHALL discard the partial word.
REQ-037 After reset release, the block SHALL wait in IDLE for iSTART.

Verification
REQ-038 Pulse iSTART -> oRD_LOAD high 4 cycles, then oRD high 32 cycles, then oWORD_VALID rises 33 cycles after the first oRD.
REQ-039 Feed iRD_DATA[13] pattern 1,0,1,0,... -> oWORD=32'h55555555; feed all 1s -> 32'hFFFFFFFF.
REQ-040 Hold iWORD_ACK=0 for 100 cycles in PRESENT -> oWORD_VALID stays 1, oWORD is unchanged, no oRD; raise ACK -> VALID drops next cycle; hold ACK high -> no new fetch until ACK returns to 0.
REQ-041 Full frame with immediate ACK -> exactly 2400 words, oWORD_COUNT=2400, one oFRAME_DONE pulse, 76800 oRD cycles total.
REQ-042 iABORT during word 10 FETCH -> IDLE next cycle, oRD=0, no oFRAME_DONE, oWORD_COUNT=9; a new iSTART restarts with oRD_LOAD.
REQ-043 Assert iRST_N=0 mid-PRESENT -> all outputs are 0 immediately, without waiting for a clock edge.
